// File: rtl/stage1_message_scheduler_pkg.sv
// Shared constants and state encoding for the stage-1 message scheduler.
// Sits in front of the stage2/3/4 encode/decode pipeline.
package stage1_message_scheduler_pkg;

  localparam int MAX_ORIGINAL_DATA_BITS = 16;
  localparam int DEF_TIMEOUT            = 16;
  localparam int DEF_MAX_CREDITS        = 8;
  localparam int DEF_CRED_W             = 4;
  localparam int TIMER_W                = 16;

  typedef enum logic {
    SCH_COLLECT = 1'b0,
    SCH_ISSUE   = 1'b1
  } sch_state_e;

endpackage

// File: rtl/stage1_credit_counter.sv
// Up/down saturating credit counter with a sticky overflow flag.
// One credit is spent per issued block and one is returned per pipeline completion.
module stage1_credit_counter #(
  parameter int MAX_CREDITS = 8,
  parameter int CRED_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [CRED_W-1:0] count,
  output logic              overflow
);

  localparam logic [CRED_W-1:0] FULL = CRED_W'(MAX_CREDITS);

  // NOTE: non-blocking assignments only in clocked blocks, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= FULL;
      overflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count == FULL) overflow <= 1'b1;
          else               count    <= count + CRED_W'(1);
        end
        2'b01: begin
          if (count != '0) count <= count - CRED_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stage1_message_scheduler.sv
// Packs up to three input words into a block and issues it into the pipeline,
// flow-controlled by credits because the pipeline itself cannot stall.
module stage1_message_scheduler
  import stage1_message_scheduler_pkg::*;
#(
  parameter int DATA_W      = MAX_ORIGINAL_DATA_BITS,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int MAX_CREDITS = DEF_MAX_CREDITS,
  parameter int CRED_W      = DEF_CRED_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush_req,
  input  logic              message_en_ret,
  output logic [DATA_W-1:0] original_data_1,
  output logic [DATA_W-1:0] original_data_2,
  output logic [DATA_W-1:0] original_data_3,
  output logic [2:0]        slot_mask,
  output logic              message_en_in,
  output logic [CRED_W-1:0] credits,
  output logic              credit_err
);

  sch_state_e           state, state_nxt;
  logic [1:0]           fill_cnt;
  logic [TIMER_W-1:0]   timer;
  logic                 accept;
  logic                 timeout_hit;

  assign in_ready      = (state == SCH_COLLECT) && (fill_cnt < 2'd3);
  assign accept        = in_valid && in_ready;
  // Strobe is decoded purely from registers so the pipeline sees no input-to-output path.
  assign message_en_in = (state == SCH_ISSUE) && (credits != '0);
  assign timeout_hit   = (TIMEOUT != 0) && (fill_cnt != 2'd0) &&
                         (timer == TIMER_W'(TIMEOUT - 1));

  stage1_credit_counter #(
    .MAX_CREDITS (MAX_CREDITS),
    .CRED_W      (CRED_W)
  ) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (message_en_ret),
    .dec      (message_en_in),
    .count    (credits),
    .overflow (credit_err)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      SCH_COLLECT: begin
        // The third accept moves straight to ISSUE so the strobe follows one cycle later.
        if ((accept && fill_cnt == 2'd2) ||
            (fill_cnt != 2'd0 && (flush_req || timeout_hit)))
          state_nxt = SCH_ISSUE;
      end
      SCH_ISSUE: begin
        if (message_en_in) state_nxt = SCH_COLLECT;
      end
      default: state_nxt = SCH_COLLECT;
    endcase
  end

  // NOTE: slot data registers are reset too, since unfilled slots must read 0 from power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= SCH_COLLECT;
      fill_cnt        <= 2'd0;
      timer           <= '0;
      slot_mask       <= 3'b000;
      original_data_1 <= '0;
      original_data_2 <= '0;
      original_data_3 <= '0;
    end else begin
      state <= state_nxt;
      if (message_en_in) begin
        // Data regs keep the issued values; only the mask says the block is gone.
        fill_cnt  <= 2'd0;
        slot_mask <= 3'b000;
        timer     <= '0;
      end else begin
        if (accept) begin
          fill_cnt <= fill_cnt + 2'd1;
          case (fill_cnt)
            2'd0: begin
              original_data_1 <= in_data;
              original_data_2 <= '0;
              original_data_3 <= '0;
              slot_mask[0]    <= 1'b1;
            end
            2'd1: begin
              original_data_2 <= in_data;
              slot_mask[1]    <= 1'b1;
            end
            default: begin
              original_data_3 <= in_data;
              slot_mask[2]    <= 1'b1;
            end
          endcase
        end
        if (accept && fill_cnt == 2'd0)
          timer <= '0;
        else if (fill_cnt != 2'd0 && timer != '1)
          timer <= timer + TIMER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stage1_message_scheduler.sv
// Self-checking bench for stage1_message_scheduler: a scoreboard of expected
// blocks is filled as words are driven and drained on each message_en_in.
module tb_stage1_message_scheduler;
  import stage1_message_scheduler_pkg::*;

  localparam int W = MAX_ORIGINAL_DATA_BITS;

  typedef struct packed {
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
    logic [2:0]   m;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         flush_req = 1'b0;
  logic         message_en_ret = 1'b0;
  logic [W-1:0] original_data_1, original_data_2, original_data_3;
  logic [2:0]   slot_mask;
  logic         message_en_in;
  logic [3:0]   credits;
  logic         credit_err;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   last_strobe_cyc = 0;
  blk_t sb[$];

  stage1_message_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .flush_req       (flush_req),
    .message_en_ret  (message_en_ret),
    .original_data_1 (original_data_1),
    .original_data_2 (original_data_2),
    .original_data_3 (original_data_3),
    .slot_mask       (slot_mask),
    .message_en_in   (message_en_in),
    .credits         (credits),
    .credit_err      (credit_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard drain: every strobe must match the oldest expected block.
  always @(negedge clk) begin
    if (rst_n && message_en_in) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      check("strobe_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        blk_t e;
        e = sb.pop_front();
        check("blk_d1", 64'(original_data_1), 64'(e.d1));
        check("blk_d2", 64'(original_data_2), 64'(e.d2));
        check("blk_d3", 64'(original_data_3), 64'(e.d3));
        check("blk_mask", 64'(slot_mask), 64'(e.m));
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic put(input logic [W-1:0] d, output int acc_cyc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("put_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic put_block(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    int t;
    sb.push_back('{d1: a, d2: b, d3: c, m: 3'b111});
    put(a, t);
    put(b, t);
    put(c, t);
  endtask

  task automatic wait_strobe(input int n0, input int budget, input string tag);
    int n;
    n = 0;
    while (strobe_cnt <= n0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(strobe_cnt > n0), 64'd1);
  endtask

  task automatic ret_pulse();
    message_en_ret = 1'b1;
    @(posedge clk); #1;
    message_en_ret = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int t, t2, n0;

    // 1. reset state
    idle(2);
    rst_n = 1'b1;
    idle(1);
    @(negedge clk);
    check("rst_credits", 64'(credits), 64'd8);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_en", 64'(message_en_in), 64'd0);
    check("rst_mask", 64'(slot_mask), 64'd0);
    check("rst_d1", 64'(original_data_1), 64'd0);
    check("rst_err", 64'(credit_err), 64'd0);
    @(posedge clk); #1;

    // 2. three-word block, one-cycle latency after the third accept
    n0 = strobe_cnt;
    sb.push_back('{d1: 16'hA, d2: 16'hB, d3: 16'hC, m: 3'b111});
    put(16'hA, t);
    put(16'hB, t);
    put(16'hC, t);
    wait_strobe(n0, 10, "full_strobe_seen");
    check("full_latency", 64'(last_strobe_cyc - t), 64'd0);
    @(negedge clk);
    check("strobe_one_cycle", 64'(message_en_in), 64'd0);
    check("credits_after_one", 64'(credits), 64'd7);
    check("hold_d3_after_issue", 64'(original_data_3), 64'hC);
    check("mask_cleared", 64'(slot_mask), 64'd0);
    @(posedge clk); #1;

    // 3. single word forced out by the timeout
    n0 = strobe_cnt;
    sb.push_back('{d1: 16'h5, d2: 16'h0, d3: 16'h0, m: 3'b001});
    put(16'h5, t);
    wait_strobe(n0, 40, "timeout_strobe_seen");
    check("timeout_latency", 64'(last_strobe_cyc - t), 64'd16);

    // 4. flush of a two-word block, then flush of an empty block
    idle(2);
    n0 = strobe_cnt;
    sb.push_back('{d1: 16'h1, d2: 16'h2, d3: 16'h0, m: 3'b011});
    put(16'h1, t);
    put(16'h2, t);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    wait_strobe(n0, 10, "flush_strobe_seen");
    check("flush_latency", 64'(last_strobe_cyc - t), 64'd1);
    idle(2);
    n0 = strobe_cnt;
    flush_req = 1'b1;
    idle(5);
    flush_req = 1'b0;
    idle(20);
    check("empty_flush_no_strobe", 64'(strobe_cnt), 64'(n0));
    check("credits_after_three", 64'(credits), 64'd5);

    // 5. exhaust credits, then stall the ninth block
    repeat (3) ret_pulse();
    @(negedge clk);
    check("credits_refilled", 64'(credits), 64'd8);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++)
      put_block(W'(16'h100 + 3 * i), W'(16'h101 + 3 * i), W'(16'h102 + 3 * i));
    idle(3);
    check("credits_exhausted", 64'(credits), 64'd0);
    n0 = strobe_cnt;
    put_block(16'hD1, 16'hD2, 16'hD3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_no_en", 64'(message_en_in), 64'd0);
      check("stall_ready_low", 64'(in_ready), 64'd0);
      check("stall_d2_stable", 64'(original_data_2), 64'hD2);
      check("stall_mask_stable", 64'(slot_mask), 64'b111);
    end
    @(posedge clk); #1;
    ret_pulse();
    wait_strobe(n0, 10, "stalled_block_issued");
    idle(1);
    check("credits_after_stall", 64'(credits), 64'd0);

    // 6. coincident issue and return, overflow, reset mid-block
    repeat (3) ret_pulse();
    put(16'hE1, t);
    put(16'hE2, t2);
    sb.push_back('{d1: 16'hE1, d2: 16'hE2, d3: 16'h0, m: 3'b011});
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    @(negedge clk);
    check("coincident_en", 64'(message_en_in), 64'd1);
    message_en_ret = 1'b1;
    @(posedge clk); #1;
    message_en_ret = 1'b0;
    @(negedge clk);
    check("coincident_credits", 64'(credits), 64'd3);
    @(posedge clk); #1;
    repeat (5) ret_pulse();
    @(negedge clk);
    check("credits_full", 64'(credits), 64'd8);
    check("no_err_yet", 64'(credit_err), 64'd0);
    @(posedge clk); #1;
    ret_pulse();
    @(negedge clk);
    check("overflow_err", 64'(credit_err), 64'd1);
    check("overflow_saturate", 64'(credits), 64'd8);
    @(posedge clk); #1;

    n0 = strobe_cnt;
    put(16'hF1, t);
    put(16'hF2, t);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(40);
    check("reset_discard_no_strobe", 64'(strobe_cnt), 64'(n0));
    check("reset_mask", 64'(slot_mask), 64'd0);
    check("reset_err_cleared", 64'(credit_err), 64'd0);
    check("reset_credits", 64'(credits), 64'd8);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
